// File: rtl/spi_slave_pkg.sv
// Shared types for the SPI slave endpoint: FSM states, per-frame mode and edge decode.
package spi_slave_pkg;

    // Wide enough for any practical MAX_CHAR; the top zero-extends its char_len port into it.
    localparam int unsigned CharLenW = 8;

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StDone
    } state_e;

    typedef struct packed {
        logic                cpol;
        logic                cpha;
        logic                lsb_first;
        logic [CharLenW-1:0] char_len;
    } mode_t;

    typedef struct packed {
        logic sample;
        logic shift;
    } edges_t;

    function automatic edges_t decode_edges(input logic cpol, input logic cpha,
                                            input logic rise, input logic fall);
        edges_t e;
        logic   lead;
        logic   trail;
        lead     = cpol ? fall : rise;
        trail    = cpol ? rise : fall;
        e.sample = cpha ? trail : lead;
        e.shift  = cpha ? lead : trail;
        return e;
    endfunction

endpackage

// File: rtl/spi_slave_port_if.sv
// Pad bus from the master core plus the parallel tx/rx handshakes of the slave endpoint.
interface spi_slave_port_if #(
    parameter int unsigned NUM_SS   = 8,
    parameter int unsigned MAX_CHAR = 32
);
    logic                sclk_pad_o;
    logic [NUM_SS-1:0]   ss_pad_o;
    logic                mosi_pad_o;
    logic                miso_pad_i;
    logic                miso_oe;

    logic [MAX_CHAR-1:0] tx_data;
    logic                tx_valid;
    logic                tx_ready;
    logic [MAX_CHAR-1:0] rx_data;
    logic                rx_valid;
    logic                rx_ready;

    modport slave (
        input  sclk_pad_o, ss_pad_o, mosi_pad_o, tx_data, tx_valid, rx_ready,
        output miso_pad_i, miso_oe, tx_ready, rx_data, rx_valid
    );

    modport master (
        output sclk_pad_o, ss_pad_o, mosi_pad_o, tx_data, tx_valid, rx_ready,
        input  miso_pad_i, miso_oe, tx_ready, rx_data, rx_valid
    );

endinterface

// File: rtl/spi_pin_sync.sv
// Two-flop synchroniser with one history flop; edges come from the last two stages.
module spi_pin_sync #(
    parameter logic ResetVal = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {3{ResetVal}};
        end else begin
            sync_q <= {sync_q[1:0], din};
        end
    end

    assign level = sync_q[1];
    assign rise  = sync_q[1] & ~sync_q[2];
    assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_slave_port.sv
// Oversampling SPI slave: all CPOL/CPHA modes, either bit order, runtime character length,
// parallel characters exchanged over valid/ready.
module spi_slave_port
    import spi_slave_pkg::*;
#(
    parameter int unsigned         NUM_SS   = 8,
    parameter int unsigned         SLAVE_ID = 0,
    parameter int unsigned         MAX_CHAR = 32,
    parameter logic [MAX_CHAR-1:0] TX_IDLE  = '1,
    localparam int unsigned        LenW     = $clog2(MAX_CHAR) + 1
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    input  logic            cpol,
    input  logic            cpha,
    input  logic            lsb_first,
    input  logic [LenW-1:0] char_len,
    spi_slave_port_if.slave bus,
    output logic            rx_overrun,
    output logic            tx_underrun,
    output logic            frame_abort
);

    localparam logic [CharLenW-1:0] MaxLen = CharLenW'(MAX_CHAR);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic ss_lvl, ss_rise, ss_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;

    spi_pin_sync #(.ResetVal(1'b0)) u_sync_sclk (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .din   (bus.sclk_pad_o),
        .level (sclk_lvl),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_pin_sync #(.ResetVal(1'b1)) u_sync_ss (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .din   (bus.ss_pad_o[SLAVE_ID]),
        .level (ss_lvl),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    spi_pin_sync #(.ResetVal(1'b0)) u_sync_mosi (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .din   (bus.mosi_pad_o),
        .level (mosi_lvl),
        .rise  (mosi_rise),
        .fall  (mosi_fall)
    );

    logic unused_pins;
    assign unused_pins = ^{sclk_lvl, ss_rise, mosi_rise, mosi_fall, bus.ss_pad_o};

    state_e                state_q, state_d;
    mode_t                 mode_q, mode_d;
    logic [CharLenW-1:0]   cnt_q, cnt_d;
    logic [MAX_CHAR-1:0]   tx_sr_q, tx_sr_d;
    logic [MAX_CHAR-1:0]   rx_sr_q, rx_sr_d;
    logic [MAX_CHAR-1:0]   rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    // Swallow the next shift edge: the first leading edge (cpha=1) or the trailing edge that
    // follows the last sample of a back-to-back character (cpha=0).
    logic                  skip_q, skip_d;

    logic                  selected;
    edges_t                edges;
    logic [CharLenW-1:0]   len_eff;
    logic [CharLenW-1:0]   cnt_inc;
    logic                  last_bit;
    logic [MAX_CHAR-1:0]   tx_msb_vec;
    logic                  tx_bit;
    logic [MAX_CHAR-1:0]   rx_aligned;

    logic                  load;
    logic                  rx_take;
    logic                  tx_ready_c;

    assign selected = ~ss_lvl;
    assign edges    = decode_edges(mode_q.cpol, mode_q.cpha, sclk_rise, sclk_fall);

    always_comb begin
        if (mode_q.char_len == '0 || mode_q.char_len > MaxLen) begin
            len_eff = MaxLen;
        end else begin
            len_eff = mode_q.char_len;
        end
    end

    assign cnt_inc    = cnt_q + CharLenW'(1);
    assign last_bit   = edges.sample && (cnt_inc == len_eff);
    assign tx_msb_vec = tx_sr_q >> (len_eff - CharLenW'(1));
    assign tx_bit     = mode_q.lsb_first ? tx_sr_q[0] : tx_msb_vec[0];
    assign rx_aligned = mode_q.lsb_first ? (rx_sr_q >> (MaxLen - len_eff)) : rx_sr_q;

    // State register and datapath registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q    <= StIdle;
            mode_q     <= '0;
            cnt_q      <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            skip_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            skip_q     <= skip_d;
        end
    end

    // Next state: a released select always wins over a coincident sclk edge.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (ss_fall) state_d = StActive;
            end
            StActive: begin
                if (!selected) begin
                    state_d = StIdle;
                end else if (last_bit) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = selected ? StActive : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs and control strobes.
    always_comb begin
        load        = 1'b0;
        rx_take     = 1'b0;
        rx_overrun  = 1'b0;
        frame_abort = 1'b0;
        unique case (state_q)
            StIdle: begin
                load = ss_fall;
            end
            StActive: begin
                frame_abort = !selected && (cnt_q != '0);
            end
            StDone: begin
                rx_take    = !rx_valid_q || bus.rx_ready;
                rx_overrun = rx_valid_q && !bus.rx_ready;
                load       = selected;
            end
            default: ;
        endcase
        tx_ready_c  = load && bus.tx_valid;
        tx_underrun = load && !bus.tx_valid;
    end

    assign bus.tx_ready   = tx_ready_c;
    assign bus.miso_oe    = (state_q != StIdle);
    assign bus.miso_pad_i = bus.miso_oe && (!mode_q.cpha || !skip_q) && tx_bit;
    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;

    // Datapath next state.
    always_comb begin
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        skip_d     = skip_q;

        if (rx_valid_q && bus.rx_ready) rx_valid_d = 1'b0;

        if (state_q == StIdle && ss_fall) begin
            mode_d.cpol      = cpol;
            mode_d.cpha      = cpha;
            mode_d.lsb_first = lsb_first;
            mode_d.char_len  = CharLenW'(char_len);
        end

        if (state_q == StActive && selected) begin
            if (edges.sample) begin
                cnt_d   = cnt_inc;
                rx_sr_d = mode_q.lsb_first ? {mosi_lvl, rx_sr_q[MAX_CHAR-1:1]}
                                           : {rx_sr_q[MAX_CHAR-2:0], mosi_lvl};
            end
            if (edges.shift) begin
                if (skip_q) begin
                    skip_d = 1'b0;
                end else begin
                    tx_sr_d = mode_q.lsb_first ? (tx_sr_q >> 1) : (tx_sr_q << 1);
                end
            end
        end

        if (rx_take) begin
            rx_data_d  = rx_aligned;
            rx_valid_d = 1'b1;
        end

        if (load) begin
            tx_sr_d = bus.tx_valid ? bus.tx_data : TX_IDLE;
            rx_sr_d = '0;
            cnt_d   = '0;
            skip_d  = (state_q == StIdle) ? cpha : 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_slave_port.sv
// Directed bench for spi_slave_port: a behavioural SPI master drives the pads and compares
// both directions of each exchange against hand-computed characters.
module tb_spi_slave_port;

    localparam int unsigned NumSs   = 8;
    localparam int unsigned SlaveId = 2;
    localparam int unsigned MaxChar = 32;
    localparam int          Half    = 6;

    logic       clk;
    logic       rst_n;
    logic       cpol, cpha, lsb_first;
    logic [5:0] char_len;
    logic       rx_overrun, tx_underrun, frame_abort;

    spi_slave_port_if #(.NUM_SS(NumSs), .MAX_CHAR(MaxChar)) bus ();

    spi_slave_port #(
        .NUM_SS   (NumSs),
        .SLAVE_ID (SlaveId),
        .MAX_CHAR (MaxChar),
        .TX_IDLE  ('1)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .cpol        (cpol),
        .cpha        (cpha),
        .lsb_first   (lsb_first),
        .char_len    (char_len),
        .bus         (bus),
        .rx_overrun  (rx_overrun),
        .tx_underrun (tx_underrun),
        .frame_abort (frame_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_ready, n_under, n_over, n_abort, n_oe;
    initial begin
        n_ready = 0; n_under = 0; n_over = 0; n_abort = 0; n_oe = 0;
    end

    // Pulse counters, sampled a little after each active edge.
    always begin
        @(posedge clk);
        #3;
        if (bus.tx_ready) n_ready++;
        if (tx_underrun)  n_under++;
        if (rx_overrun)   n_over++;
        if (frame_abort)  n_abort++;
        if (bus.miso_oe)  n_oe++;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_mode(input logic cp, input logic ch, input logic lsb, input int len);
        cpol           = cp;
        cpha           = ch;
        lsb_first      = lsb;
        char_len       = 6'(len);
        bus.sclk_pad_o = cp;
        wait_clks(4);
    endtask

    task automatic select_slave(input logic valid, input logic [31:0] data);
        bus.tx_data               = data;
        bus.tx_valid              = valid;
        bus.ss_pad_o[SlaveId]     = 1'b0;
        wait_clks(6);
        bus.tx_valid              = 1'b0;
    endtask

    task automatic deselect_slave();
        wait_clks(Half);
        bus.ss_pad_o[SlaveId] = 1'b1;
        wait_clks(6);
    endtask

    // Clocks nclk bits of a len-bit character; returns what the master saw on miso.
    task automatic xfer(input int len, input int nclk, input logic [31:0] mtx,
                        output logic [31:0] mrx);
        int idx;
        mrx = '0;
        for (int i = 0; i < nclk; i++) begin
            idx = lsb_first ? i : len - 1 - i;
            if (!cpha) begin
                bus.mosi_pad_o = mtx[idx];
                wait_clks(Half);
                mrx[idx]       = bus.miso_pad_i;
                bus.sclk_pad_o = ~cpol;
                wait_clks(Half);
                bus.sclk_pad_o = cpol;
            end else begin
                wait_clks(Half);
                bus.sclk_pad_o = ~cpol;
                bus.mosi_pad_o = mtx[idx];
                wait_clks(Half);
                mrx[idx]       = bus.miso_pad_i;
                bus.sclk_pad_o = cpol;
            end
        end
    endtask

    task automatic consume_rx(input string tag);
        bus.rx_ready = 1'b1;
        wait_clks(1);
        bus.rx_ready = 1'b0;
        check_eq(tag, {31'd0, bus.rx_valid}, 32'd0);
    endtask

    logic [31:0] mrx, mrx2;
    int          c_ready, c_under, c_over, c_abort, c_oe;

    task automatic snap();
        c_ready = n_ready; c_under = n_under; c_over = n_over;
        c_abort = n_abort; c_oe = n_oe;
    endtask

    initial begin
        rst_n          = 1'b0;
        cpol           = 1'b0;
        cpha           = 1'b0;
        lsb_first      = 1'b0;
        char_len       = 6'd8;
        bus.sclk_pad_o = 1'b0;
        bus.ss_pad_o   = '1;
        bus.mosi_pad_o = 1'b0;
        bus.tx_data    = '0;
        bus.tx_valid   = 1'b0;
        bus.rx_ready   = 1'b0;
        wait_clks(3);
        check_eq("rst_miso", {31'd0, bus.miso_pad_i}, 32'd0);
        check_eq("rst_oe", {31'd0, bus.miso_oe}, 32'd0);
        check_eq("rst_tx_ready", {31'd0, bus.tx_ready}, 32'd0);
        check_eq("rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        check_eq("rst_rx_data", bus.rx_data, 32'd0);
        rst_n = 1'b1;
        wait_clks(4);

        // Mode 0, 8-bit MSB first.
        set_mode(1'b0, 1'b0, 1'b0, 8);
        snap();
        select_slave(1'b1, 32'hA5);
        check_eq("m0_oe", {31'd0, bus.miso_oe}, 32'd1);
        xfer(8, 8, 32'h3C, mrx);
        deselect_slave();
        check_eq("m0_miso", mrx, 32'hA5);
        check_eq("m0_rx_data", bus.rx_data, 32'h3C);
        check_eq("m0_rx_valid", {31'd0, bus.rx_valid}, 32'd1);
        check_eq("m0_tx_ready_cnt", n_ready - c_ready, 32'd1);
        check_eq("m0_end_underrun", n_under - c_under, 32'd1);
        check_eq("m0_oe_after", {31'd0, bus.miso_oe}, 32'd0);
        consume_rx("m0_consume");

        // Modes 1..3, 16-bit LSB first.
        for (int m = 1; m < 4; m++) begin
            set_mode(m[1], m[0], 1'b1, 16);
            select_slave(1'b1, 32'h1234);
            xfer(16, 16, 32'hBEEF, mrx);
            deselect_slave();
            check_eq($sformatf("mode%0d_miso", m), mrx, 32'h1234);
            check_eq($sformatf("mode%0d_rx_data", m), bus.rx_data, 32'hBEEF);
            consume_rx($sformatf("mode%0d_consume", m));
        end

        // Back-to-back characters under one select, consumer stalled.
        set_mode(1'b0, 1'b0, 1'b0, 8);
        snap();
        select_slave(1'b1, 32'h11);
        bus.tx_data  = 32'h22;
        bus.tx_valid = 1'b1;
        xfer(8, 8, 32'h5A, mrx);
        bus.tx_valid = 1'b0;
        xfer(8, 8, 32'hC3, mrx2);
        deselect_slave();
        check_eq("b2b_miso0", mrx, 32'h11);
        check_eq("b2b_miso1", mrx2, 32'h22);
        check_eq("b2b_rx_data", bus.rx_data, 32'h5A);
        check_eq("b2b_rx_valid", {31'd0, bus.rx_valid}, 32'd1);
        check_eq("b2b_overrun_cnt", n_over - c_over, 32'd1);
        check_eq("b2b_tx_ready_cnt", n_ready - c_ready, 32'd2);
        consume_rx("b2b_consume");

        // Nothing offered at select: idle pattern goes out.
        snap();
        select_slave(1'b0, 32'h0);
        bus.tx_data  = 32'h00;
        bus.tx_valid = 1'b1;
        xfer(8, 8, 32'h42, mrx);
        bus.tx_valid = 1'b0;
        deselect_slave();
        check_eq("udr_miso", mrx, 32'hFF);
        check_eq("udr_underrun_cnt", n_under - c_under, 32'd1);
        check_eq("udr_rx_data", bus.rx_data, 32'h42);
        consume_rx("udr_consume");

        // Select released after 5 of 8 bits, then a clean frame.
        snap();
        select_slave(1'b1, 32'h00);
        xfer(8, 5, 32'hFF, mrx);
        deselect_slave();
        check_eq("abort_cnt", n_abort - c_abort, 32'd1);
        check_eq("abort_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        select_slave(1'b1, 32'h00);
        xfer(8, 8, 32'h81, mrx);
        deselect_slave();
        check_eq("post_abort_rx_data", bus.rx_data, 32'h81);
        check_eq("post_abort_rx_valid", {31'd0, bus.rx_valid}, 32'd1);

        // Another slave selected: this one stays silent and keeps its held character.
        snap();
        bus.tx_valid    = 1'b1;
        bus.ss_pad_o[5] = 1'b0;
        wait_clks(6);
        xfer(8, 8, 32'h99, mrx);
        wait_clks(Half);
        bus.ss_pad_o[5] = 1'b1;
        bus.tx_valid    = 1'b0;
        wait_clks(6);
        check_eq("other_oe_cnt", n_oe - c_oe, 32'd0);
        check_eq("other_tx_ready_cnt", n_ready - c_ready, 32'd0);
        check_eq("other_underrun_cnt", n_under - c_under, 32'd0);
        check_eq("other_rx_data", bus.rx_data, 32'h81);

        // Reset mid-frame.
        snap();
        select_slave(1'b1, 32'h5A);
        xfer(8, 3, 32'hF0, mrx);
        check_eq("mid_oe_before", {31'd0, bus.miso_oe}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_oe", {31'd0, bus.miso_oe}, 32'd0);
        check_eq("mid_rst_miso", {31'd0, bus.miso_pad_i}, 32'd0);
        check_eq("mid_rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        check_eq("mid_rst_rx_data", bus.rx_data, 32'd0);
        bus.ss_pad_o[SlaveId] = 1'b1;
        bus.sclk_pad_o        = cpol;
        wait_clks(4);
        rst_n = 1'b1;
        wait_clks(6);
        check_eq("mid_rst_abort_cnt", n_abort - c_abort, 32'd0);
        check_eq("mid_rst_oe_after", {31'd0, bus.miso_oe}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
